wb_initiator: RTL and testbench

- Wishbone initiator (master) for the team's simple 4-phase Wishbone peripherals, such as the UART.
- Accepts single-beat read/write requests on a valid/ready command port and runs one bus transaction per request.
- Returns read data and status on a valid/ready response port.
- Sits between a CPU/test sequencer and the peripheral bus; enforces the bus polarity convention wb_we LOW = write, HIGH = read.

---
 rtl/wb_initiator.sv | 144 ++++++++++++++
 tb/tb_wb_initiator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// Single-beat Wishbone initiator: one valid/ready request becomes one 4-phase
// stb/ack bus transaction, answered on a valid/ready response port.
module wb_initiator #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data_out,
    input  logic [DATA_W-1:0] wb_data_in,
    output logic              wb_we,
    output logic              wb_stb,
    input  logic              wb_ack
);

    typedef enum logic [1:0] {IDLE, STROBE, RELEASE, RESPOND} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_stb;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_error;
    logic [7:0]        r_err_count;

    logic              w_to_hit;
    logic [7:0]        w_err_inc;

    assign w_to_hit  = (r_cnt == TO_LAST);
    assign w_err_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_stb       <= 1'b0;
            r_we        <= 1'b1;
            r_addr      <= '0;
            r_dout      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_dout      <= req_wdata;
                        r_we        <= ~req_write;
                        // An ack still high from the last transfer holds off the strobe.
                        r_stb       <= ~wb_ack;
                        r_cnt       <= '0;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= 1'b0;
                        r_state     <= STROBE;
                    end
                end
                STROBE: begin
                    if (!r_stb) begin
                        if (!wb_ack) begin
                            r_stb <= 1'b1;
                            r_cnt <= '0;
                        end else if (w_to_hit) begin
                            r_rsp_error <= 1'b1;
                            r_err_count <= w_err_inc;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESPOND;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else if (wb_ack) begin
                        r_rsp_rdata <= r_we ? wb_data_in : '0;
                        r_stb       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= RELEASE;
                    end else if (w_to_hit) begin
                        r_stb       <= 1'b0;
                        r_cnt       <= '0;
                        r_rsp_error <= 1'b1;
                        r_err_count <= w_err_inc;
                        r_state     <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!wb_ack) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESPOND;
                    end else if (w_to_hit) begin
                        // A transaction is counted once even if both phases fail.
                        if (!r_rsp_error) begin
                            r_err_count <= w_err_inc;
                        end
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESPOND;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign err_count   = r_err_count;
    assign wb_addr     = r_addr;
    assign wb_data_out = r_dout;
    assign wb_we       = r_we;
    assign wb_stb      = r_stb;

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: a configurable bus responder plus a queue of
// expected {error, rdata} pairs pushed on request accept and popped on response.
module tb_wb_initiator;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          wb_clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          busy;
    logic [7:0]    err_count;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data_out;
    logic [DW-1:0] wb_data_in;
    logic          wb_we;
    logic          wb_stb;
    logic          wb_ack;

    always #5 wb_clk = ~wb_clk;

    wb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .wb_clk(wb_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy), .err_count(err_count),
        .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack)
    );

    int checks = 0;
    int errors = 0;
    int err_model = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Responder: 0 = ack after ack_delay stb cycles, 1 = never ack, 2 = ack then hold high
    int         rsp_mode = 0;
    int         ack_delay = 1;
    logic [7:0] rd_value = 8'h00;
    int         r_cnt_tb = 0;

    always @(posedge wb_clk) begin
        if (reset) begin
            wb_ack   <= 1'b0;
            r_cnt_tb <= 0;
        end else if (rsp_mode == 1) begin
            wb_ack   <= 1'b0;
            r_cnt_tb <= 0;
        end else if (wb_ack) begin
            wb_data_in <= ~rd_value;
            if (!wb_stb && rsp_mode != 2) wb_ack <= 1'b0;
        end else if (wb_stb) begin
            if (r_cnt_tb == ack_delay - 1) begin
                wb_ack     <= 1'b1;
                wb_data_in <= rd_value;
                r_cnt_tb   <= 0;
            end else begin
                r_cnt_tb <= r_cnt_tb + 1;
            end
        end else begin
            r_cnt_tb <= 0;
        end
    end

    // Bus monitor: strobe length, fields at strobe rise, stability while high
    int            stb_cyc = 0;
    logic          stb_we;
    logic [AW-1:0] stb_addr;
    logic [DW-1:0] stb_dout;
    logic          prev_stb = 1'b0;

    always @(posedge wb_clk) begin
        #1;
        if (wb_stb === 1'b1) begin
            stb_cyc++;
            if (!prev_stb) begin
                stb_we   = wb_we;
                stb_addr = wb_addr;
                stb_dout = wb_data_out;
                check("stb_rise_ack_low", wb_ack, 0);
            end else begin
                check("stb_hold_addr", wb_addr, stb_addr);
                check("stb_hold_we", wb_we, stb_we);
            end
        end
        prev_stb = (wb_stb === 1'b1);
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [8:0] expv);
        int n = 0;
        @(negedge wb_clk);
        stb_cyc   = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1);
        exp_q.push_back(expv);
        @(posedge wb_clk); #1;
        req_valid = 1'b0;
        check("req_ready_busy", req_ready, 0);
        check("busy_set", busy, 1);
    endtask

    task automatic finish(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int exp_cyc, input int exp_lat, input int bp);
        int n = 0;
        logic [8:0] e;
        logic [7:0] rd0;
        logic er0;
        while (!rsp_valid && n < 100) begin
            check("req_ready_held_low", req_ready, 0);
            @(posedge wb_clk); #1;
            n++;
        end
        check("rsp_latency", n, exp_lat);
        check("rsp_valid", rsp_valid, 1);
        check("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e[7:0]);
            check("rsp_error", rsp_error, e[8]);
            if (e[8] && err_model != 255) err_model++;
        end
        check("err_count", err_count, err_model);
        rd0 = rsp_rdata;
        er0 = rsp_error;
        for (int i = 0; i < bp; i++) begin
            @(posedge wb_clk); #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, rd0);
            check("bp_error", rsp_error, er0);
            check("bp_busy", busy, 1);
            check("bp_no_stb", wb_stb, 0);
        end
        rsp_ready = 1'b1;
        @(posedge wb_clk); #1;
        rsp_ready = 1'b0;
        check("rsp_cleared", rsp_valid, 0);
        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        check("stb_cycles", stb_cyc, exp_cyc);
        if (exp_cyc > 0) begin
            check("bus_we", stb_we, !wr);
            check("bus_addr", stb_addr, a);
            if (wr) check("bus_wdata", stb_dout, wd);
        end
        $display("txn %s addr=%0d rdata=0x%02h err=%0d lat=%0d stb=%0d err_count=%0d",
                 wr ? "WR" : "RD", a, rd0, er0, n, stb_cyc, err_count);
    endtask

    task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [8:0] expv, input int exp_cyc, input int exp_lat,
                          input int bp);
        issue(wr, a, wd, expv);
        finish(wr, a, wd, exp_cyc, exp_lat, bp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        wb_data_in = '0;
        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk);
        reset = 1'b0;

        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 1);
        check("rst_addr", wb_addr, 0);
        check("rst_dout", wb_data_out, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_error", rsp_error, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);

        // Write, ack one cycle after strobe: minimum latency
        rsp_mode = 0; ack_delay = 1;
        do_txn(1'b1, 2'd0, 8'h41, {1'b0, 8'h00}, 2, 4, 0);

        // Read with a slower ack; data changes after the ack edge
        ack_delay = 3; rd_value = 8'h5A;
        do_txn(1'b0, 2'd1, 8'h00, {1'b0, 8'h5A}, 4, 6, 0);

        // No ack: strobe times out
        rsp_mode = 1;
        do_txn(1'b1, 2'd2, 8'h77, {1'b1, 8'h00}, TO, 5, 0);

        // Stuck ack: release phase times out
        rsp_mode = 2; ack_delay = 1; rd_value = 8'h33;
        do_txn(1'b0, 2'd3, 8'h00, {1'b1, 8'h00}, 2, 6, 0);

        // Next request must wait for ack to fall before strobing
        issue(1'b1, 2'd3, 8'h99, {1'b0, 8'h00});
        check("pend_stb_a0", wb_stb, 0);
        @(posedge wb_clk); #1;
        check("pend_stb_a1", wb_stb, 0);
        @(posedge wb_clk); #1;
        check("pend_stb_a2", wb_stb, 0);
        check("pend_ack_high", wb_ack, 1);
        rsp_mode = 0;
        finish(1'b1, 2'd3, 8'h99, 2, 6, 0);

        // Response backpressure
        ack_delay = 2; rd_value = 8'h96;
        do_txn(1'b0, 2'd2, 8'h00, {1'b0, 8'h96}, 3, 5, 5);

        // Error counter saturation
        rsp_mode = 1;
        for (int i = 0; i < 256; i++) begin
            do_txn(1'b1, 2'd2, 8'(i), {1'b1, 8'h00}, TO, 5, 0);
        end
        check("err_count_saturated", err_count, 255);

        // Reset while strobing
        issue(1'b1, 2'd2, 8'h11, {1'b1, 8'h00});
        exp_q.delete();
        @(posedge wb_clk); #1;
        check("mid_stb_high", wb_stb, 1);
        @(negedge wb_clk);
        reset = 1'b1;
        @(posedge wb_clk); #1;
        check("mid_rst_stb", wb_stb, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_we", wb_we, 1);
        @(negedge wb_clk);
        reset = 1'b0;
        err_model = 0;
        $display("txn RESET during strobe err_count=%0d", err_count);

        // A read after reset completes normally
        rsp_mode = 0; ack_delay = 2; rd_value = 8'hC3;
        do_txn(1'b0, 2'd1, 8'h00, {1'b0, 8'hC3}, 3, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
